// File: rtl/sys_defs.sv
// Shared memory-interface types and constants for the O-store writer.
package sys_defs;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  localparam ADDR O_BASE = 32'h0001_0000;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } ostore_state_e;

  // Byte address of 64-bit line idx relative to base.
  function automatic ADDR line_addr(input ADDR base, input logic [31:0] idx);
    return base + (idx << 3);
  endfunction

endpackage

// File: rtl/o_store_engine_fifo.sv
// Synchronous MEM_BLOCK FIFO with async active-low reset and synchronous clear.
module ostore_fifo
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr_i,
  input  logic     push_i,
  input  MEM_BLOCK wdata_i,
  input  logic     pop_i,
  output MEM_BLOCK head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  MEM_BLOCK    mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full_o)  wr_d = wr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/o_store_engine.sv
// Streams NUM_LINES output rows into memory as MEM_STORE transactions, then raises done.
// Optional OSTORE_STALL_CNT_EN adds the stall_cycles bus-stall counter output.
module o_store_engine
  import sys_defs::*;
#(
  parameter int unsigned NUM_LINES  = 512,
  parameter ADDR         BASE_ADDR  = O_BASE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [63:0]                      in_data,
  output logic                             in_ready,
  output logic                             bus_req,
  input  logic                             bus_grant,
  output MEM_COMMAND                       proc2mem_command,
  output logic [31:0]                      proc2mem_addr,
  output logic [63:0]                      proc2mem_data,
  input  logic [3:0]                       mem2proc_transaction_tag,
  output logic [$clog2(NUM_LINES+1)-1:0]   lines_written,
`ifdef OSTORE_STALL_CNT_EN
  output logic [31:0]                      stall_cycles,
`endif
  output logic                             done
);

  localparam int unsigned  CW       = $clog2(NUM_LINES+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_LINES - 1);
  localparam logic [CW-1:0] ALL_CNT  = CW'(NUM_LINES);

  ostore_state_e   state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   written_q, written_d;
  logic [CW-1:0]   acc_in_q, acc_in_d;
  logic            done_q, done_d;

  logic            run;
  logic            start_run;
  logic            push;
  logic            issue;
  logic            accept;
  logic            fifo_full;
  logic            fifo_empty;
  MEM_BLOCK        fifo_head;

  assign run       = (state_q == OS_RUN);
  assign start_run = start && (state_q != OS_RUN);
  assign in_ready  = run && !fifo_full && (acc_in_q < ALL_CNT);
  assign push      = in_valid && in_ready;
  assign bus_req   = run && !fifo_empty;
  assign issue     = bus_req && bus_grant;
  assign accept    = issue && (mem2proc_transaction_tag != '0);

  ostore_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (start_run),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (accept),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (issue) begin
      proc2mem_command = MEM_STORE;
      proc2mem_addr    = line_addr(BASE_ADDR, 32'(idx_q));
      proc2mem_data    = fifo_head;
    end
  end

  // DONE is entered on the final acceptance itself so done is visible one cycle later.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    written_d = written_q;
    acc_in_d  = acc_in_q;
    done_d    = done_q;
    if (start_run) begin
      state_d   = OS_RUN;
      idx_d     = '0;
      written_d = '0;
      acc_in_d  = '0;
      done_d    = 1'b0;
    end else if (run) begin
      if (push) acc_in_d = acc_in_q + CW'(1);
      if (accept) begin
        idx_d     = idx_q + CW'(1);
        written_d = written_q + CW'(1);
        if (written_q == LAST_IDX) begin
          state_d = OS_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= OS_IDLE;
      idx_q     <= '0;
      written_q <= '0;
      acc_in_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      written_q <= written_d;
      acc_in_q  <= acc_in_d;
      done_q    <= done_d;
    end
  end

  assign lines_written = written_q;
  assign done          = done_q;

`ifdef OSTORE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_run) begin
      stall_d = '0;
    end else if (bus_req && (!bus_grant || mem2proc_transaction_tag == '0)
                 && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
